// File: rtl/src_rr_scheduler.sv
// Round-robin scheduler merging free-running sources onto one valid/ready stream.
// Each source owns a small FIFO; per-source drop counters record beats lost to a full FIFO.
module src_rr_scheduler #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(NUM_SRC)-1:0]   out_src,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         clear_stats,
  output logic [NUM_SRC*CNT_W-1:0]     drop_count,
  output logic [NUM_SRC-1:0]           overflow
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem      [NUM_SRC][DEPTH];
  logic [PW-1:0]     rd_ptr   [NUM_SRC];
  logic [PW-1:0]     wr_ptr   [NUM_SRC];
  logic [CW-1:0]     fill     [NUM_SRC];
  logic [CNT_W-1:0]  drop_cnt [NUM_SRC];
  logic [SW-1:0]     rr_ptr;

  logic [NUM_SRC-1:0] non_empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] drop;
  logic               load;
  logic               grant_found;
  logic [SW-1:0]      grant;
  int                 scan_idx;

  // Output handshake: a beat transfers on a rising edge where out_valid && out_ready.
  // out_data/out_src stay stable while out_valid && !out_ready; the output
  // register reloads whenever it is empty or its beat is being accepted.
  assign load = !out_valid || out_ready;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      non_empty[i] = (fill[i] != '0);
      full[i]      = (fill[i] == CW'(DEPTH));
    end
  end

  // First non-empty FIFO at or after the RR pointer, wrapping at NUM_SRC.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_SRC) scan_idx = scan_idx - NUM_SRC;
      if (!grant_found && non_empty[SW'(scan_idx)]) begin
        grant_found = 1'b1;
        grant       = SW'(scan_idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = load && grant_found && (grant == SW'(i));
      // A full FIFO still accepts a beat when it is popped at the same edge.
      push[i] = src_valid[i] && (!full[i] || pop[i]);
      drop[i] = src_valid[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset && push[i]) mem[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i]   <= '0;
        wr_ptr[i]   <= '0;
        fill[i]     <= '0;
        drop_cnt[i] <= '0;
      end
      overflow  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        fill[i] <= fill[i] + CW'(push[i]) - CW'(pop[i]);
        if (clear_stats) begin
          drop_cnt[i] <= '0;
          overflow[i] <= 1'b0;
        end else if (drop[i]) begin
          if (drop_cnt[i] != {CNT_W{1'b1}}) drop_cnt[i] <= drop_cnt[i] + CNT_W'(1);
          overflow[i] <= 1'b1;
        end
      end
      if (load) begin
        if (grant_found) begin
          out_valid <= 1'b1;
          out_data  <= mem[grant][rd_ptr[grant]];
          out_src   <= grant;
          rr_ptr    <= (grant == SW'(NUM_SRC - 1)) ? '0 : grant + SW'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_drop
    assign drop_count[g*CNT_W +: CNT_W] = drop_cnt[g];
  end

endmodule

// File: tb/tb_src_rr_scheduler.sv
// Directed and randomized checks of src_rr_scheduler against a queue-based reference model.
module tb_src_rr_scheduler;

  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 8;

  logic                       clock;
  logic                       reset;
  logic [NUM_SRC*DATA_W-1:0]  src_data;
  logic [NUM_SRC-1:0]         src_valid;
  logic [DATA_W-1:0]          out_data;
  logic [1:0]                 out_src;
  logic                       out_valid;
  logic                       out_ready;
  logic                       clear_stats;
  logic [NUM_SRC*CNT_W-1:0]   drop_count;
  logic [NUM_SRC-1:0]         overflow;

  src_rr_scheduler #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .clear_stats(clear_stats), .drop_count(drop_count), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [NUM_SRC][$];
  int                m_ptr;
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_src;
  int                m_drop [NUM_SRC];
  bit                m_ovf  [NUM_SRC];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [2:0] v, input logic [23:0] d,
                            input logic rdy, input logic clr, input logic rst_n);
    int win;
    int pre [NUM_SRC];
    logic [DATA_W-1:0] popped;
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        mq[i].delete();
        m_drop[i] = 0;
        m_ovf[i]  = 0;
      end
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
      return;
    end
    win = -1;
    popped = '0;
    for (int i = 0; i < NUM_SRC; i++) pre[i] = mq[i].size();
    if (!m_valid || rdy) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_SRC;
        if (win < 0 && mq[idx].size() > 0) win = idx;
      end
      if (win >= 0) popped = mq[win].pop_front();
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i]) begin
        if (pre[i] < DEPTH || win == i) mq[i].push_back(d[i*DATA_W +: DATA_W]);
        else begin
          if (m_drop[i] < (1 << CNT_W) - 1) m_drop[i]++;
          m_ovf[i] = 1;
        end
      end
      if (clr) begin
        m_drop[i] = 0;
        m_ovf[i]  = 0;
      end
    end
    if (!m_valid || rdy) begin
      if (win >= 0) begin
        m_valid = 1; m_data = popped; m_src = win; m_ptr = (win + 1) % NUM_SRC;
      end else m_valid = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [2:0] v, input logic [23:0] d,
                      input logic rdy, input logic clr, input logic rst_n);
    src_valid   = v;
    src_data    = d;
    out_ready   = rdy;
    clear_stats = clr;
    reset       = rst_n;
    @(posedge clock);
    model_edge(v, d, rdy, clr, rst_n);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_src", 32'(out_src), 32'(m_src));
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      check("drop_count", 32'(drop_count[i*CNT_W +: CNT_W]), 32'(m_drop[i]));
      check("overflow", 32'(overflow[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(3'b000, 24'h0, rdy, 1'b0, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    src_valid = '0; src_data = '0; out_ready = 1'b0; clear_stats = 1'b0; reset = 1'b0;

    // Reset held, then a single beat from source 1
    for (int i = 0; i < 3; i++) step(3'b000, 24'h0, 1'b0, 1'b0, 1'b0);
    check("t1_rst_valid", 32'(out_valid), 32'h0);
    check("t1_rst_drops", 32'(drop_count), 32'h0);
    idle(1, 1'b1);
    step(3'b010, 24'h005A00, 1'b1, 1'b0, 1'b1);
    check("t1_lat_k", 32'(out_valid), 32'h0);
    idle(1, 1'b1);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h5A);
    check("t1_src", 32'(out_src), 32'h1);
    idle(1, 1'b1);
    check("t1_gone", 32'(out_valid), 32'h0);

    // Round-robin fairness from a freshly reset pointer
    step(3'b000, 24'h0, 1'b1, 1'b0, 1'b0);
    step(3'b111, 24'h302010, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("t2_d0", 32'(out_data), 32'h10); check("t2_s0", 32'(out_src), 32'h0);
    idle(1, 1'b1);
    check("t2_d1", 32'(out_data), 32'h20); check("t2_s1", 32'(out_src), 32'h1);
    idle(1, 1'b1);
    check("t2_d2", 32'(out_data), 32'h30); check("t2_s2", 32'(out_src), 32'h2);
    step(3'b111, 24'h312111, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("t2_r0", 32'(out_src), 32'h0); check("t2_rd0", 32'(out_data), 32'h11);
    idle(1, 1'b1);
    check("t2_r1", 32'(out_src), 32'h1);
    idle(1, 1'b1);
    check("t2_r2", 32'(out_src), 32'h2);
    check("t2_nodrop", 32'(drop_count), 32'h0);
    idle(2, 1'b1);

    // Stall and overflow on source 0
    for (int b = 1; b <= 4; b++) step(3'b001, 24'(b), 1'b0, 1'b0, 1'b1);
    check("t3_hold", 32'(out_data), 32'h1);
    check("t3_drop", 32'(drop_count[7:0]), 32'h1);
    check("t3_ovf", 32'(overflow), 32'h1);
    idle(1, 1'b1);
    check("t3_o2", 32'(out_data), 32'h2);
    idle(1, 1'b1);
    check("t3_o3", 32'(out_data), 32'h3);
    idle(1, 1'b1);
    check("t3_empty", 32'(out_valid), 32'h0);

    // Full FIFO accepting a beat alongside a pop
    for (int b = 0; b < 3; b++) step(3'b100, 24'((8'h40 + b) << 16), 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 8; b++) begin
      step(3'b100, 24'((8'h43 + b) << 16), 1'b1, 1'b0, 1'b1);
      check("t4_order", 32'(out_data), 32'(8'h41 + b));
    end
    check("t4_nodrop", 32'(drop_count[23:16]), 32'h0);
    idle(4, 1'b1);

    // Drop counter saturation, then clear colliding with a drop
    for (int b = 0; b < 303; b++) step(3'b010, 24'($urandom_range(0, 255) << 8), 1'b0, 1'b0, 1'b1);
    check("t5_sat", 32'(drop_count[15:8]), 32'hFF);
    check("t5_ovf", 32'(overflow[1]), 32'h1);
    step(3'b010, 24'h00EE00, 1'b0, 1'b1, 1'b1);
    check("t5_clr_cnt", 32'(drop_count[15:8]), 32'h0);
    check("t5_clr_ovf", 32'(overflow), 32'h0);
    idle(4, 1'b1);

    // Reset mid-operation discards everything buffered
    for (int b = 0; b < 3; b++) step(3'b111, 24'($urandom), 1'b0, 1'b0, 1'b1);
    step(3'b000, 24'h0, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      idle(1, 1'b1);
      check("t6_quiet", 32'(out_valid), 32'h0);
    end
    step(3'b001, 24'h000077, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("t6_new", 32'(out_data), 32'h77);
    check("t6_src", 32'(out_src), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] v;
      logic rdy, clr, rst_n;
      v     = 3'($urandom_range(0, 7));
      rdy   = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step(v, 24'($urandom), rdy, clr, rst_n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/src_rr_scheduler.md
Name: src_rr_scheduler

Overview:
Shares a single 8-bit output stream between free-running producer blocks (one/two/three style: data plus valid, no backpressure).
- Each source's beats are captured into a small per-source FIFO.
- FIFOs are drained one beat per cycle onto a valid/ready output, using round-robin arbitration.
- Source ID is tagged on each output beat.
- Overflow is counted per source.
- Replaces fixed counter-window muxing in parent blocks with fair, lossless-when-possible scheduling.

Parameters:
NUM_SRC, 3, number of requesting sources (2..8)
DATA_W, 8, data width per source
DEPTH, 2, per-source FIFO depth in entries (power of 2, >=2)
CNT_W, 8, width of each per-source drop counter

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
src_data  input  NUM_SRC*DATA_W  source i data at bits [i*DATA_W +: DATA_W]
src_valid  input  NUM_SRC  source i beat present this cycle
out_data  output  DATA_W  scheduled beat data
out_src  output  $clog2(NUM_SRC)  index of source that produced out_data
out_valid  output  1  out_data/out_src valid
out_ready  input  1  downstream accepts beat when out_valid && out_ready
clear_stats  input  1  zero drop_count and overflow
drop_count  output  NUM_SRC*CNT_W  per-source count of dropped beats, saturating
overflow  output  NUM_SRC  sticky per-source drop flag

Behaviour:
- Reset (reset==0 at a rising edge):
  - all FIFOs empty; out_valid=0, out_data=0, out_src=0
  - drop_count=0, overflow=0
  - RR pointer set so source 0 has highest priority
  - Reset mid-operation discards all buffered and in-flight beats; nothing is emitted afterwards.
- Capture: at each edge, for each i with src_valid[i]=1:
  - FIFO i not full, or a pop from FIFO i occurs at the same edge -> push src_data[i].
  - Otherwise -> beat dropped; drop_count[i] increments, saturating at 2^CNT_W-1; overflow[i] set.
- Output register update ("load slot"): occurs at an edge where out_valid==0 or out_ready==1.
  - The arbiter picks the first non-empty FIFO scanning from the RR pointer upward, with wrap.
  - That FIFO is popped into out_data/out_src, out_valid=1, and the RR pointer moves to winner+1 (mod NUM_SRC).
  - If all FIFOs are empty at a load slot: out_valid=0 and the pointer is unchanged.
- Arbiter sees FIFO state as of the start of the cycle. A beat pushed at edge k is eligible at edge k+1 at the earliest. Minimum latency is 2 edges: src_valid sampled at edge k, out_valid high after edge k+1.
- Stall: while out_valid && !out_ready, out_data and out_src hold stable and no FIFO is popped.
- Throughput: one output beat per cycle while any FIFO is non-empty and out_ready=1. The aggregate input rate exceeds this when several sources are active together; FIFOs absorb bursts up to DEPTH.
- Fairness: with all sources continuously non-empty and out_ready=1, grants cycle 0,1,2,0,1,2,...
- Per-source FIFO order is strict FIFO; the interleave between sources is RR order only.
- clear_stats=1: drop_count and overflow are zeroed at that edge. If a drop occurs at the same edge, clear wins: the result is 0 and the flag stays clear. FIFO and data path are unaffected.
- Unused index values of out_src (NUM_SRC not a power of 2) never appear.
- Widths: FIFO occupancy counters are $clog2(DEPTH)+1 bits. The RR pointer wraps explicitly at NUM_SRC, not by natural binary overflow.

Test Plan:
1. Reset and single beat: hold reset=0 for 3 cycles, check out_valid=0 and drop_count=0. Release reset, out_ready=1, pulse src_valid[1] with 0x5A at edge k -> out_valid=1, out_data=0x5A, out_src=1 after edge k+1, out_valid=0 after edge k+2.
2. Round-robin fairness: out_ready=1, one edge with all three sources valid (0x10, 0x20, 0x30) -> outputs 0x10/src0, 0x20/src1, 0x30/src2 on consecutive cycles. Repeat the burst -> order restarts at src0 (pointer=0 after src2), no drops.
3. Stall and overflow: out_ready=0, src_valid[0] high for 4 consecutive edges with data 1,2,3,4 -> beat 1 sits in the output register, 2 and 3 in the FIFO, beat 4 dropped; drop_count[0]=1, overflow[0]=1, out_data holds 1. Release out_ready -> outputs 1, 2, 3.
4. Full with simultaneous pop: FIFO 2 full, out_ready=1, src_valid[2] every edge while only source 2 is active -> zero drops, outputs in order.
5. Saturation and clear: with CNT_W=8, force 300 drops on src1 -> drop_count[1]=255. Assert clear_stats on the same edge as a drop -> drop_count[1]=0, overflow[1]=0.
6. Reset mid-operation: fill all FIFOs with out_ready=0, pull reset low one edge, then out_ready=1 -> no beats emitted, out_valid stays 0 until new src_valid.
